exe_unit: RTL and testbench
===========================

# exe_unit

Execute stage of the five-stage pipelined processor, together with its EXE/MEM pipeline register. It sits between the ID/EXE register and the memory stage.
- It resolves operands through optional data forwarding from the MEM and WB stages.
- It performs the ALU operation and evaluates branches combinationally.
- It registers the results toward the memory stage.

## Interface

One clock; reset is synchronous and active-low. Clock port `clk`, reset port `rst`.

Parameters: none; all widths are fixed.

Ports, as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- sw  in  1  forwarding enable (1 = forwarding on)
- PC_in  in  32  PC+4 of the instruction in EXE
- WB_EN_EXE  in  1  write-back enable
- MEM_CMD_EXE  in  2  [0] = memory read, [1] = memory write
- EXE_CMD_EXE  in  6  [3:0] = ALU op, [5:4] = branch type
- Val1_EXE  in  32  operand A from the register file
- Val2_EXE  in  32  operand B: register value, or sign-extended immediate
- Reg2_EXE  in  32  rt register value (store data / branch compare)
- is_immediate_EXE  in  1  1 = Val2_EXE is an immediate
- Src1_EXE, Src2_EXE, Dst_EXE  in  5 each  source and destination register numbers
- Dst_WB  in  5  destination register in WB
- WB_EN_WB_out  in  1  WB write enable
- Result_WB_to_IR  in  32  WB result value
- PC_src_out_EXE  out  1  branch taken (combinational)
- br_address_out_EXE  out  32  branch target (combinational)
- WB_EN_out_EXE, MEM_CMD_out_EXE, Dst_EXE_out_EXE  out  1/2/5  combinational pass-through, used by ID hazard detection
- WB_EN_MEM, MEM_CMD_MEM, Dst_MEM, PC_MEM  out  1/2/5/32  registered controls and PC
- ALU_res_MEM  out  32  registered ALU result
- src2_val_MEM  out  32  registered store data

## Operation

**Forwarding function fwd(src, dflt):**
- Condition MEM: sw=1, WB_EN_MEM=1, Dst_MEM==src, src!=0 → ALU_res_MEM.
- Otherwise, condition WB: sw=1, WB_EN_WB_out=1, Dst_WB==src, src!=0 → Result_WB_to_IR.
- Otherwise → dflt.
- MEM takes priority over WB.

**Operand selection:**
- A = fwd(Src1_EXE, Val1_EXE).
- B = Val2_EXE if is_immediate_EXE, else fwd(Src2_EXE, Val2_EXE).
- store = fwd(Src2_EXE, Reg2_EXE). This applies regardless of is_immediate_EXE.

**ALU op** (32-bit, wrap-around, no flags; shift amount B[4:0]):
- 0 ADD: A+B
- 1 SUB: A−B
- 2 AND
- 3 OR
- 4 NOR
- 5 XOR
- 6 SLA: A<<B
- 7 SLL: A<<B
- 8 SRA: arithmetic A>>>B
- 9 SRL: logical A>>B
- 10–15: result 0

**Branch type:**
- 00 none → PC_src_out_EXE=0
- 01 BEZ → taken when A==0
- 10 BNE → taken when A!=store
- 11 JMP → always taken

Branch target: br_address_out_EXE = PC_in + {Val2_EXE[29:0],2'b00}. The target is computed in every cycle, whether or not the branch is taken.

**Control handling:**
- Controls pass through unchanged. The block never modifies WB_EN or MEM_CMD; the decoder clears them for branches.
- The upstream logic uses PC_src_out_EXE to redirect fetch and to flush IF/ID and ID/EXE.

## Timing

- ALU result, forwarding muxes, branch decision, target and pass-through outputs are purely combinational from the inputs and the current register contents.
- The EXE/MEM register captures on the rising edge:
  - if rst==0: WB_EN_MEM, MEM_CMD_MEM, Dst_MEM, PC_MEM, ALU_res_MEM and src2_val_MEM all become 0;
  - otherwise: WB_EN_EXE, MEM_CMD_EXE, Dst_EXE, PC_in, the ALU result and store are captured.
- Latency is one cycle from the EXE inputs to the *_MEM outputs. There is no stall or enable input: the register loads every cycle.
- MEM forwarding reads the block's own registered values (previous instruction). WB forwarding uses the external WB inputs (the instruction two ahead).
- Reset asserted mid-stream clears the register on that edge. The combinational outputs still track the inputs during reset; with the register cleared, no MEM forward occurs.
- Register 0 is never forwarded.

## Test plan

1. **Reset.** Hold rst=0 for one edge with nonzero inputs → all *_MEM outputs are 0. Release rst → the next edge captures the inputs.
2. **ADD and shifts, no forwarding.** sw=0:
   - op0, A=5, B=7 → ALU_res_MEM=12 one edge later;
   - op8, A=0x80000000, B=4 → 0xF8000000;
   - op9 with the same operands → 0x08000000.
3. **MEM forward.** sw=1. Cycle 1: ADD writes r3=0x10. Cycle 2: Src1=3, Val1=0, Val2=1, op0 → result 0x11. Repeat with sw=0 → result 1.
4. **Forwarding priority and r0.**
   - WB has Dst=4 with value 0x20, MEM has Dst=4 with value 0x30, Src1=4 → A uses 0x30.
   - Src1=0 with Dst_MEM=0 and WB_EN_MEM=1 → no forward.
5. **Branches.** PC_in=0x40, Val2=3:
   - BEZ with A=0 → PC_src=1, target 0x4C;
   - BNE with A==store → PC_src=0;
   - JMP → PC_src=1.
6. **Immediate and store.** is_immediate=1, Val2=0xFFFFFFFF, Src2 matches Dst_MEM, op0, A=1 → result 0. In the same cycle, src2_val_MEM takes the forwarded MEM value.

Source files
------------

// File: rtl/exe_unit.sv
// Execute stage with operand forwarding, ALU, branch resolution and the EXE/MEM pipeline register.
// Forwarding prefers the younger MEM-stage result over the WB-stage result; register 0 is never forwarded.
module exe_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw,
  input  logic [31:0] PC_in,
  input  logic        WB_EN_EXE,
  input  logic [1:0]  MEM_CMD_EXE,
  input  logic [5:0]  EXE_CMD_EXE,
  input  logic [31:0] Val1_EXE,
  input  logic [31:0] Val2_EXE,
  input  logic [31:0] Reg2_EXE,
  input  logic        is_immediate_EXE,
  input  logic [4:0]  Src1_EXE,
  input  logic [4:0]  Src2_EXE,
  input  logic [4:0]  Dst_EXE,
  input  logic [4:0]  Dst_WB,
  input  logic        WB_EN_WB_out,
  input  logic [31:0] Result_WB_to_IR,
  output logic        PC_src_out_EXE,
  output logic [31:0] br_address_out_EXE,
  output logic        WB_EN_out_EXE,
  output logic [1:0]  MEM_CMD_out_EXE,
  output logic [4:0]  Dst_EXE_out_EXE,
  output logic        WB_EN_MEM,
  output logic [1:0]  MEM_CMD_MEM,
  output logic [4:0]  Dst_MEM,
  output logic [31:0] PC_MEM,
  output logic [31:0] ALU_res_MEM,
  output logic [31:0] src2_val_MEM
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLA = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  logic        wb_en_q, wb_en_d;
  logic [1:0]  mem_cmd_q, mem_cmd_d;
  logic [4:0]  dst_q, dst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] src2_val_q, src2_val_d;

  logic        mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [31:0] a_val, fwd2_val, b_val, store_val, alu_res;
  logic        br_taken;

  // Hit detection: the MEM hit reads this block's own registered destination.
  assign mem_hit1 = sw && wb_en_q && (dst_q == Src1_EXE) && (Src1_EXE != 5'd0);
  assign mem_hit2 = sw && wb_en_q && (dst_q == Src2_EXE) && (Src2_EXE != 5'd0);
  assign wb_hit1  = sw && WB_EN_WB_out && (Dst_WB == Src1_EXE) && (Src1_EXE != 5'd0);
  assign wb_hit2  = sw && WB_EN_WB_out && (Dst_WB == Src2_EXE) && (Src2_EXE != 5'd0);

  always_comb begin
    a_val = Val1_EXE;
    if (mem_hit1)     a_val = alu_res_q;
    else if (wb_hit1) a_val = Result_WB_to_IR;

    fwd2_val  = Val2_EXE;
    store_val = Reg2_EXE;
    if (mem_hit2) begin
      fwd2_val  = alu_res_q;
      store_val = alu_res_q;
    end else if (wb_hit2) begin
      fwd2_val  = Result_WB_to_IR;
      store_val = Result_WB_to_IR;
    end

    // Immediates bypass forwarding; store data is forwarded regardless.
    b_val = is_immediate_EXE ? Val2_EXE : fwd2_val;
  end

  always_comb begin
    alu_res = 32'd0;
    case (EXE_CMD_EXE[3:0])
      OP_ADD:  alu_res = a_val + b_val;
      OP_SUB:  alu_res = a_val - b_val;
      OP_AND:  alu_res = a_val & b_val;
      OP_OR:   alu_res = a_val | b_val;
      OP_NOR:  alu_res = ~(a_val | b_val);
      OP_XOR:  alu_res = a_val ^ b_val;
      OP_SLA:  alu_res = a_val << b_val[4:0];
      OP_SLL:  alu_res = a_val << b_val[4:0];
      OP_SRA:  alu_res = $unsigned($signed(a_val) >>> b_val[4:0]);
      OP_SRL:  alu_res = a_val >> b_val[4:0];
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (EXE_CMD_EXE[5:4])
      BR_NONE: br_taken = 1'b0;
      BR_BEZ:  br_taken = (a_val == 32'd0);
      BR_BNE:  br_taken = (a_val != store_val);
      BR_JMP:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  assign PC_src_out_EXE     = br_taken;
  assign br_address_out_EXE = PC_in + {Val2_EXE[29:0], 2'b00};
  assign WB_EN_out_EXE      = WB_EN_EXE;
  assign MEM_CMD_out_EXE    = MEM_CMD_EXE;
  assign Dst_EXE_out_EXE    = Dst_EXE;

  always_comb begin
    wb_en_d    = WB_EN_EXE;
    mem_cmd_d  = MEM_CMD_EXE;
    dst_d      = Dst_EXE;
    pc_d       = PC_in;
    alu_res_d  = alu_res;
    src2_val_d = store_val;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_cmd_q  <= 2'b00;
      dst_q      <= 5'd0;
      pc_q       <= 32'd0;
      alu_res_q  <= 32'd0;
      src2_val_q <= 32'd0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_cmd_q  <= mem_cmd_d;
      dst_q      <= dst_d;
      pc_q       <= pc_d;
      alu_res_q  <= alu_res_d;
      src2_val_q <= src2_val_d;
    end
  end

  assign WB_EN_MEM    = wb_en_q;
  assign MEM_CMD_MEM  = mem_cmd_q;
  assign Dst_MEM      = dst_q;
  assign PC_MEM       = pc_q;
  assign ALU_res_MEM  = alu_res_q;
  assign src2_val_MEM = src2_val_q;

endmodule

// File: tb/tb_exe_unit.sv
// Directed bench for exe_unit: reset, ALU ops, forwarding, branches and store-data forwarding.
module tb_exe_unit;

  logic        clk;
  logic        rst;
  logic        sw;
  logic [31:0] PC_in;
  logic        WB_EN_EXE;
  logic [1:0]  MEM_CMD_EXE;
  logic [5:0]  EXE_CMD_EXE;
  logic [31:0] Val1_EXE, Val2_EXE, Reg2_EXE;
  logic        is_immediate_EXE;
  logic [4:0]  Src1_EXE, Src2_EXE, Dst_EXE, Dst_WB;
  logic        WB_EN_WB_out;
  logic [31:0] Result_WB_to_IR;
  logic        PC_src_out_EXE;
  logic [31:0] br_address_out_EXE;
  logic        WB_EN_out_EXE;
  logic [1:0]  MEM_CMD_out_EXE;
  logic [4:0]  Dst_EXE_out_EXE;
  logic        WB_EN_MEM;
  logic [1:0]  MEM_CMD_MEM;
  logic [4:0]  Dst_MEM;
  logic [31:0] PC_MEM, ALU_res_MEM, src2_val_MEM;

  int n_checks = 0;
  int n_fail   = 0;

  exe_unit dut (
    .clk(clk), .rst(rst), .sw(sw), .PC_in(PC_in),
    .WB_EN_EXE(WB_EN_EXE), .MEM_CMD_EXE(MEM_CMD_EXE), .EXE_CMD_EXE(EXE_CMD_EXE),
    .Val1_EXE(Val1_EXE), .Val2_EXE(Val2_EXE), .Reg2_EXE(Reg2_EXE),
    .is_immediate_EXE(is_immediate_EXE), .Src1_EXE(Src1_EXE), .Src2_EXE(Src2_EXE),
    .Dst_EXE(Dst_EXE), .Dst_WB(Dst_WB), .WB_EN_WB_out(WB_EN_WB_out),
    .Result_WB_to_IR(Result_WB_to_IR), .PC_src_out_EXE(PC_src_out_EXE),
    .br_address_out_EXE(br_address_out_EXE), .WB_EN_out_EXE(WB_EN_out_EXE),
    .MEM_CMD_out_EXE(MEM_CMD_out_EXE), .Dst_EXE_out_EXE(Dst_EXE_out_EXE),
    .WB_EN_MEM(WB_EN_MEM), .MEM_CMD_MEM(MEM_CMD_MEM), .Dst_MEM(Dst_MEM),
    .PC_MEM(PC_MEM), .ALU_res_MEM(ALU_res_MEM), .src2_val_MEM(src2_val_MEM)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic clear_inputs();
    sw = 1'b0; PC_in = 32'd0; WB_EN_EXE = 1'b0; MEM_CMD_EXE = 2'b00; EXE_CMD_EXE = 6'd0;
    Val1_EXE = 32'd0; Val2_EXE = 32'd0; Reg2_EXE = 32'd0; is_immediate_EXE = 1'b0;
    Src1_EXE = 5'd0; Src2_EXE = 5'd0; Dst_EXE = 5'd0;
    Dst_WB = 5'd0; WB_EN_WB_out = 1'b0; Result_WB_to_IR = 32'd0;
  endtask

  // Outputs are sampled 1ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an ADD that writes val into register dst (A=val, B=0).
  task automatic issue_write(input logic [4:0] dst, input logic [31:0] val);
    clear_inputs();
    WB_EN_EXE = 1'b1; Dst_EXE = dst; Val1_EXE = val;
    tick();
  endtask

  task automatic alu_case(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    clear_inputs();
    EXE_CMD_EXE = {2'b00, op}; Val1_EXE = a; Val2_EXE = b;
    tick();
    n_checks++;
    if (ALU_res_MEM !== exp) begin
      n_fail++;
      $display("FAIL alu_%s: got %h expected %h", name, ALU_res_MEM, exp);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    WB_EN_EXE = 1'b1; MEM_CMD_EXE = 2'b10; Dst_EXE = 5'd7; PC_in = 32'h100;
    Val1_EXE = 32'd5; Val2_EXE = 32'd7; Reg2_EXE = 32'hAB;
    tick();
    n_checks++; if (WB_EN_MEM !== 1'b0)      begin n_fail++; $display("FAIL rst_wb_en: got %b expected 0", WB_EN_MEM); end
    n_checks++; if (MEM_CMD_MEM !== 2'b00)   begin n_fail++; $display("FAIL rst_mem_cmd: got %b expected 00", MEM_CMD_MEM); end
    n_checks++; if (Dst_MEM !== 5'd0)        begin n_fail++; $display("FAIL rst_dst: got %0d expected 0", Dst_MEM); end
    n_checks++; if (PC_MEM !== 32'd0)        begin n_fail++; $display("FAIL rst_pc: got %h expected 0", PC_MEM); end
    n_checks++; if (ALU_res_MEM !== 32'd0)   begin n_fail++; $display("FAIL rst_alu: got %h expected 0", ALU_res_MEM); end
    n_checks++; if (src2_val_MEM !== 32'd0)  begin n_fail++; $display("FAIL rst_src2: got %h expected 0", src2_val_MEM); end
    rst = 1'b1;
    tick();
    n_checks++; if (WB_EN_MEM !== 1'b1)        begin n_fail++; $display("FAIL cap_wb_en: got %b expected 1", WB_EN_MEM); end
    n_checks++; if (MEM_CMD_MEM !== 2'b10)     begin n_fail++; $display("FAIL cap_mem_cmd: got %b expected 10", MEM_CMD_MEM); end
    n_checks++; if (Dst_MEM !== 5'd7)          begin n_fail++; $display("FAIL cap_dst: got %0d expected 7", Dst_MEM); end
    n_checks++; if (PC_MEM !== 32'h100)        begin n_fail++; $display("FAIL cap_pc: got %h expected 100", PC_MEM); end
    n_checks++; if (ALU_res_MEM !== 32'd12)    begin n_fail++; $display("FAIL cap_alu: got %h expected c", ALU_res_MEM); end
    n_checks++; if (src2_val_MEM !== 32'hAB)   begin n_fail++; $display("FAIL cap_src2: got %h expected ab", src2_val_MEM); end
  endtask

  task automatic test_alu();
    alu_case("add",   4'd0,  32'd5,        32'd7,  32'd12);
    alu_case("sub",   4'd1,  32'd5,        32'd7,  32'hFFFF_FFFE);
    alu_case("and",   4'd2,  32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034);
    alu_case("or",    4'd3,  32'hF000_0001, 32'h0000_0010, 32'hF000_0011);
    alu_case("nor",   4'd4,  32'hF000_0000, 32'h0000_000F, 32'h0FFF_FFF0);
    alu_case("xor",   4'd5,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu_case("sla",   4'd6,  32'd3,        32'd4,  32'd48);
    alu_case("sll_b", 4'd7,  32'd1,        32'h21, 32'd2);
    alu_case("sra",   4'd8,  32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_case("srl",   4'd9,  32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_case("op12",  4'd12, 32'd5,        32'd7,  32'd0);
    alu_case("op15",  4'd15, 32'hFFFF_FFFF, 32'd1, 32'd0);
  endtask

  task automatic test_mem_fwd();
    issue_write(5'd3, 32'h10);
    clear_inputs();
    sw = 1'b1; Src1_EXE = 5'd3; Val2_EXE = 32'd1;
    tick();
    n_checks++; if (ALU_res_MEM !== 32'h11) begin n_fail++; $display("FAIL mem_fwd_on: got %h expected 11", ALU_res_MEM); end
    issue_write(5'd3, 32'h10);
    clear_inputs();
    sw = 1'b0; Src1_EXE = 5'd3; Val2_EXE = 32'd1;
    tick();
    n_checks++; if (ALU_res_MEM !== 32'h1) begin n_fail++; $display("FAIL mem_fwd_off: got %h expected 1", ALU_res_MEM); end
  endtask

  task automatic test_priority();
    issue_write(5'd4, 32'h30);
    clear_inputs();
    sw = 1'b1; Src1_EXE = 5'd4; WB_EN_EXE = 1'b1; Dst_EXE = 5'd9;
    Dst_WB = 5'd4; WB_EN_WB_out = 1'b1; Result_WB_to_IR = 32'h20;
    tick();
    n_checks++; if (ALU_res_MEM !== 32'h30) begin n_fail++; $display("FAIL fwd_mem_over_wb: got %h expected 30", ALU_res_MEM); end
    // MEM now holds r9, so only WB matches r4.
    clear_inputs();
    sw = 1'b1; Src1_EXE = 5'd4; Dst_WB = 5'd4; WB_EN_WB_out = 1'b1; Result_WB_to_IR = 32'h20;
    tick();
    n_checks++; if (ALU_res_MEM !== 32'h20) begin n_fail++; $display("FAIL fwd_wb: got %h expected 20", ALU_res_MEM); end
    // Register 0 never forwards, from MEM or WB, on either operand.
    issue_write(5'd0, 32'h55);
    clear_inputs();
    sw = 1'b1; Src1_EXE = 5'd0; Val1_EXE = 32'd3; Src2_EXE = 5'd0; Val2_EXE = 32'd2;
    Dst_WB = 5'd0; WB_EN_WB_out = 1'b1; Result_WB_to_IR = 32'h77;
    tick();
    n_checks++; if (ALU_res_MEM !== 32'd5) begin n_fail++; $display("FAIL fwd_r0: got %h expected 5", ALU_res_MEM); end
  endtask

  task automatic test_branch();
    clear_inputs();
    PC_in = 32'h40; Val2_EXE = 32'd3; EXE_CMD_EXE = 6'b01_0000;
    WB_EN_EXE = 1'b1; MEM_CMD_EXE = 2'b01; Dst_EXE = 5'd17;
    #1;
    n_checks++; if (PC_src_out_EXE !== 1'b1)       begin n_fail++; $display("FAIL bez_taken: got %b expected 1", PC_src_out_EXE); end
    n_checks++; if (br_address_out_EXE !== 32'h4C) begin n_fail++; $display("FAIL br_target: got %h expected 4c", br_address_out_EXE); end
    n_checks++; if (WB_EN_out_EXE !== 1'b1)        begin n_fail++; $display("FAIL pass_wb_en: got %b expected 1", WB_EN_out_EXE); end
    n_checks++; if (MEM_CMD_out_EXE !== 2'b01)     begin n_fail++; $display("FAIL pass_mem_cmd: got %b expected 01", MEM_CMD_out_EXE); end
    n_checks++; if (Dst_EXE_out_EXE !== 5'd17)     begin n_fail++; $display("FAIL pass_dst: got %0d expected 17", Dst_EXE_out_EXE); end
    Val1_EXE = 32'd1; #1;
    n_checks++; if (PC_src_out_EXE !== 1'b0) begin n_fail++; $display("FAIL bez_not_taken: got %b expected 0", PC_src_out_EXE); end
    EXE_CMD_EXE = 6'b10_0000; Val1_EXE = 32'd5; Reg2_EXE = 32'd5; #1;
    n_checks++; if (PC_src_out_EXE !== 1'b0) begin n_fail++; $display("FAIL bne_equal: got %b expected 0", PC_src_out_EXE); end
    Reg2_EXE = 32'd6; #1;
    n_checks++; if (PC_src_out_EXE !== 1'b1) begin n_fail++; $display("FAIL bne_diff: got %b expected 1", PC_src_out_EXE); end
    EXE_CMD_EXE = 6'b11_0000; #1;
    n_checks++; if (PC_src_out_EXE !== 1'b1) begin n_fail++; $display("FAIL jmp: got %b expected 1", PC_src_out_EXE); end
    EXE_CMD_EXE = 6'b00_0000; Val1_EXE = 32'd0; #1;
    n_checks++; if (PC_src_out_EXE !== 1'b0) begin n_fail++; $display("FAIL br_none: got %b expected 0", PC_src_out_EXE); end
    Val2_EXE = 32'hC000_0001; #1;
    n_checks++; if (br_address_out_EXE !== 32'h44) begin n_fail++; $display("FAIL br_target_trunc: got %h expected 44", br_address_out_EXE); end
    tick();
  endtask

  task automatic test_imm_store();
    issue_write(5'd6, 32'h77);
    clear_inputs();
    sw = 1'b1; is_immediate_EXE = 1'b1; Val2_EXE = 32'hFFFF_FFFF; Src2_EXE = 5'd6;
    Val1_EXE = 32'd1; Reg2_EXE = 32'h12;
    tick();
    n_checks++; if (ALU_res_MEM !== 32'd0)   begin n_fail++; $display("FAIL imm_no_fwd: got %h expected 0", ALU_res_MEM); end
    n_checks++; if (src2_val_MEM !== 32'h77) begin n_fail++; $display("FAIL store_fwd: got %h expected 77", src2_val_MEM); end
    // BNE compares against the forwarded store value: r6 from WB (0x99) equals A.
    clear_inputs();
    sw = 1'b1; Src2_EXE = 5'd6; Reg2_EXE = 32'h12; Val1_EXE = 32'h99; EXE_CMD_EXE = 6'b10_0000;
    Dst_WB = 5'd6; WB_EN_WB_out = 1'b1; Result_WB_to_IR = 32'h99;
    #1;
    n_checks++; if (PC_src_out_EXE !== 1'b0) begin n_fail++; $display("FAIL bne_fwd_store: got %b expected 0", PC_src_out_EXE); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue_write(5'd1, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      clear_inputs();
      sw = 1'b1; Src1_EXE = 5'd1; Val2_EXE = 32'd1; WB_EN_EXE = 1'b1; Dst_EXE = 5'd1;
      tick();
      n_checks++;
      if (ALU_res_MEM !== 32'(i)) begin
        n_fail++;
        $display("FAIL b2b_chain_%0d: got %h expected %h", i, ALU_res_MEM, 32'(i));
      end
    end
    // Reset mid-stream clears the register and stops the MEM forward.
    rst = 1'b0;
    tick();
    n_checks++; if (ALU_res_MEM !== 32'd0) begin n_fail++; $display("FAIL mid_rst: got %h expected 0", ALU_res_MEM); end
    rst = 1'b1;
    clear_inputs();
    sw = 1'b1; Src1_EXE = 5'd1; Val1_EXE = 32'd8; Val2_EXE = 32'd1;
    tick();
    n_checks++; if (ALU_res_MEM !== 32'd9) begin n_fail++; $display("FAIL post_rst_no_fwd: got %h expected 9", ALU_res_MEM); end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_alu();
    test_mem_fwd();
    test_priority();
    test_branch();
    test_imm_store();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
